dmx_frame_scheduler: RTL and testbench

// Sequences the DMX packet transmitter: holds a 512-channel shadow frame written by two requesters
// (pattern engine A, manual override B) through a round-robin write arbiter, snapshots it into the

---
 rtl/dmx_frame_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_dmx_frame_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmx_frame_scheduler.sv
// dmx_frame_scheduler
// Holds a shadow DMX frame written by two requesters through a round-robin
// arbiter. On each refresh tick it copies the shadow into the active frame,
// then resets, triggers and monitors the packet transmitter.
//
// state  | meaning
// S_IDLE | transmitter released, waiting for a pending refresh tick
// S_LOAD | active <= shadow, transmitter held in reset, tick consumed
// S_ARM  | one-cycle tx_send pulse, wait counter cleared
// S_WAIT | waiting for tx_done, aborts after TIMEOUT_CYC cycles
// S_DONE | frame completed, frame_cnt incremented
module dmx_frame_scheduler #(
  parameter int          NUM_CH      = 512,
  parameter logic [7:0]  START_CODE  = 8'h00,
  parameter int          PERIOD_CYC  = 1_250_000,
  parameter int          TIMEOUT_CYC = 2_500_000,
  localparam int         FW          = 11 * (NUM_CH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          a_wr,
  input  logic [8:0]    a_addr,
  input  logic [7:0]    a_data,
  output logic          a_ack,
  input  logic          b_wr,
  input  logic [8:0]    b_addr,
  input  logic [7:0]    b_data,
  output logic          b_ack,
  input  logic          clr_err,
  output logic [FW-1:0] tx_data,
  output logic          tx_send,
  output logic          tx_rst_n,
  input  logic          tx_done,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          overrun,
  output logic          timeout_err,
  output logic          addr_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT, S_DONE} state_t;

  localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        tick_pend_q, tick_pend_d;
  logic        last_b_q, last_b_d;
  logic        overrun_q, overrun_d;
  logic        timeout_err_q, timeout_err_d;
  logic        addr_err_q, addr_err_d;
  logic        tx_send_q, tx_send_d;
  logic        tx_rst_n_q, tx_rst_n_d;
  logic        busy_q, busy_d;

  logic [7:0]  shadow_q [NUM_CH];
  logic [7:0]  active_q [NUM_CH];

  logic        sel_a, sel_b, wr_en, wr_valid, tick;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;

  // Round-robin write grant; the loser of a contention wins the next one.
  always_comb begin
    sel_a    = a_wr & (~b_wr | last_b_q);
    sel_b    = b_wr & ~sel_a;
    a_ack    = sel_a & ~rst;
    b_ack    = sel_b & ~rst;
    wr_en    = a_ack | b_ack;
    wr_addr  = sel_a ? a_addr : b_addr;
    wr_data  = sel_a ? a_data : b_data;
    wr_valid = wr_en & (32'(wr_addr) < 32'(NUM_CH));
    last_b_d = a_ack ? 1'b0 : (b_ack ? 1'b1 : last_b_q);
  end

  // Refresh timer, sequencer next state, counters and sticky error flags.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    tick_pend_d   = tick_pend_q;
    overrun_d     = overrun_q & ~clr_err;
    timeout_err_d = timeout_err_q & ~clr_err;
    addr_err_d    = (addr_err_q & ~clr_err) | (wr_en & ~wr_valid);

    tick         = en && (period_cnt_q == PERIOD_LAST);
    period_cnt_d = en ? (tick ? 32'd0 : period_cnt_q + 32'd1) : 32'd0;

    case (state_q)
      S_IDLE: if (tick_pend_q) state_d = S_LOAD;
      S_LOAD: begin
        tick_pend_d = 1'b0;
        state_d     = S_ARM;
      end
      S_ARM: begin
        wait_cnt_d = 32'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          state_d = S_DONE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A tick landing while one is still pending is merged and flagged; the
    // tick consumed by LOAD in this same cycle does not count as pending.
    if (tick) begin
      if (tick_pend_q && (state_q != S_LOAD)) overrun_d = 1'b1;
      tick_pend_d = 1'b1;
    end

    tx_send_d  = (state_d == S_ARM);
    tx_rst_n_d = (state_d != S_LOAD);
    busy_d     = (state_d != S_IDLE);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      period_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      tick_pend_q   <= 1'b0;
      last_b_q      <= 1'b1;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      addr_err_q    <= 1'b0;
      tx_send_q     <= 1'b0;
      tx_rst_n_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      tick_pend_q   <= tick_pend_d;
      last_b_q      <= last_b_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      addr_err_q    <= addr_err_d;
      tx_send_q     <= tx_send_d;
      tx_rst_n_q    <= tx_rst_n_d;
      busy_q        <= busy_d;
    end
  end

  // Frame storage: LOAD copies the pre-write shadow, so a same-cycle write
  // lands in the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (state_q == S_LOAD) begin
        for (int i = 0; i < NUM_CH; i++) active_q[i] <= shadow_q[i];
      end
      if (wr_valid) shadow_q[wr_addr] <= wr_data;
    end
  end

  // Slot formatting: stop bits high, data LSB first, start bit low.
  always_comb begin
    tx_data       = '0;
    tx_data[10:0] = {2'b11, START_CODE, 1'b0};
    for (int k = 0; k < NUM_CH; k++) begin
      tx_data[11*(k+1) +: 11] = {2'b11, active_q[k], 1'b0};
    end
  end

  assign tx_send     = tx_send_q;
  assign tx_rst_n    = tx_rst_n_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_dmx_frame_scheduler.sv
// Testbench for dmx_frame_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a behavioural frame model.
module tb_dmx_frame_scheduler;

  localparam int NCH = 480;
  localparam int PER = 100;
  localparam int TMO = 200;
  localparam int FW  = 11 * (NCH + 1);

  logic          clk = 1'b0;
  logic          rst, en, a_wr, b_wr, clr_err, tx_done;
  logic [8:0]    a_addr, b_addr;
  logic [7:0]    a_data, b_data;
  logic          a_ack, b_ack, tx_send, tx_rst_n, busy;
  logic          overrun, timeout_err, addr_err;
  logic [15:0]   frame_cnt;
  logic [FW-1:0] tx_data;

  dmx_frame_scheduler #(
    .NUM_CH(NCH), .START_CODE(8'h00), .PERIOD_CYC(PER), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_wr(b_wr), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .clr_err(clr_err), .tx_data(tx_data), .tx_send(tx_send),
    .tx_rst_n(tx_rst_n), .tx_done(tx_done), .busy(busy),
    .frame_cnt(frame_cnt), .overrun(overrun), .timeout_err(timeout_err),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: frame contents, timer, pending tick, frame progress
  logic [7:0]  m_sh  [NCH];
  logic [7:0]  m_act [NCH];
  bit          m_last_b, m_pend, m_ovr, m_terr, m_aerr, m_was_reset;
  bit          m_in_frame, m_fin;
  int          m_age, m_tcnt;
  logic [15:0] m_fcnt;

  // transmitter stand-in
  int tx_delay, tx_cnt;
  bit tx_armed, rand_delay;
  bit obs_a_ack, obs_b_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i]  = 8'h00;
      m_act[i] = 8'h00;
    end
    m_last_b = 1'b1; m_pend = 0; m_ovr = 0; m_terr = 0; m_aerr = 0;
    m_in_frame = 0; m_fin = 0; m_age = 0; m_tcnt = 0; m_fcnt = 16'd0;
    m_was_reset = 1'b1;
  endtask

  function automatic bit e_send();
    return m_in_frame && !m_fin && (m_age == 1);
  endfunction

  function automatic bit e_rstn();
    return !m_was_reset && !(m_in_frame && !m_fin && (m_age == 0));
  endfunction

  task automatic model_update(input bit ga, input bit gb);
    bit tick, was_load;
    if (rst) begin
      model_reset();
      return;
    end
    m_was_reset = 1'b0;
    tick     = en && (m_tcnt == PER - 1);
    was_load = m_in_frame && !m_fin && (m_age == 0);

    if (clr_err) begin m_ovr = 0; m_terr = 0; m_aerr = 0; end
    if (ga && int'(a_addr) >= NCH) m_aerr = 1;
    if (gb && int'(b_addr) >= NCH) m_aerr = 1;
    if (tick && m_pend && !was_load) m_ovr = 1;

    if (!m_in_frame) begin
      if (m_pend) begin m_in_frame = 1; m_age = 0; end
    end else if (m_fin) begin
      m_fcnt = m_fcnt + 16'd1;
      m_in_frame = 0; m_fin = 0;
    end else if (m_age == 0) begin
      for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
      m_age = 1;
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (tx_done) begin
      m_fin = 1;
    end else if (m_age - 2 == TMO - 1) begin
      m_terr = 1; m_in_frame = 0;
    end else begin
      m_age++;
    end

    if (tick) m_pend = 1;
    else if (was_load) m_pend = 0;
    m_tcnt = en ? (tick ? 0 : m_tcnt + 1) : 0;

    if (ga && int'(a_addr) < NCH) m_sh[a_addr] = a_data;
    if (gb && int'(b_addr) < NCH) m_sh[b_addr] = b_data;
    if (ga) m_last_b = 1'b0;
    else if (gb) m_last_b = 1'b1;
  endtask

  task automatic check_frame();
    logic [7:0]  byt;
    logic [10:0] slot;
    for (int k = 0; k <= NCH; k++) begin
      byt  = (k == 0) ? 8'h00 : m_act[k-1];
      slot = {2'b11, byt, 1'b0};
      chk($sformatf("slot%0d", k), 32'(tx_data[11*k +: 11]), 32'(slot));
    end
  endtask

  task automatic step();
    bit ga, gb;
    ga = !rst && a_wr && (!b_wr || m_last_b);
    gb = !rst && b_wr && !ga;
    #2;
    obs_a_ack = a_ack;
    obs_b_ack = b_ack;
    chk("a_ack", 32'(a_ack), 32'(ga));
    chk("b_ack", 32'(b_ack), 32'(gb));
    @(posedge clk);
    model_update(ga, gb);
    #1;
    chk("tx_send",     32'(tx_send),     32'(e_send()));
    chk("tx_rst_n",    32'(tx_rst_n),    32'(e_rstn()));
    chk("busy",        32'(busy),        32'(m_in_frame));
    chk("frame_cnt",   32'(frame_cnt),   32'(m_fcnt));
    chk("overrun",     32'(overrun),     32'(m_ovr));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("addr_err",    32'(addr_err),    32'(m_aerr));
    if (e_send() || m_was_reset) check_frame();
    if (!e_rstn()) begin tx_done = 1'b0; tx_armed = 0; end
    if (e_send()) begin
      tx_armed = 1;
      tx_cnt   = rand_delay ? int'($urandom_range(5, 230)) : tx_delay;
    end else if (tx_armed && tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin tx_done = 1'b1; tx_armed = 0; end
    end
    if (ga) a_wr = 1'b0;
    if (gb) b_wr = 1'b0;
  endtask

  task automatic wait_send(input string tag, input int limit);
    int n = 0;
    while (!tx_send && n < limit) begin step(); n++; end
    chk(tag, 32'(tx_send), 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0] fc;
    rst = 1; en = 0; a_wr = 0; b_wr = 0; clr_err = 0; tx_done = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    tx_delay = 30; tx_cnt = 0; tx_armed = 0; rand_delay = 0;
    model_reset();
    repeat (3) step();
    chk("rst_tx_rst_n", 32'(tx_rst_n), 32'd0);
    chk("rst_slot0", 32'(tx_data[10:0]), 32'h600);
    rst = 0;

    // contention: both held, winners must alternate starting with A
    for (int i = 0; i < 6; i++) begin
      if (!a_wr) begin a_wr = 1; a_addr = 9'(i); a_data = 8'(8'h10 + i); end
      if (!b_wr) begin b_wr = 1; b_addr = 9'(100 + i); b_data = 8'(8'h20 + i); end
      step();
      chk("cont_a", 32'(obs_a_ack), 32'(i % 2 == 0));
      chk("cont_b", 32'(obs_b_ack), 32'(i % 2 == 1));
    end
    b_wr = 0;
    step();

    // out-of-range address, clear, then set-wins-over-clear
    b_wr = 1; b_addr = 9'd500; b_data = 8'hEE;
    step();
    chk("bad_ack", 32'(obs_b_ack), 32'd1);
    chk("bad_err", 32'(addr_err), 32'd1);
    clr_err = 1; step(); clr_err = 0;
    chk("clr_err", 32'(addr_err), 32'd0);
    b_wr = 1; b_addr = 9'd511; clr_err = 1; step(); clr_err = 0;
    chk("set_wins", 32'(addr_err), 32'd1);
    clr_err = 1; step(); clr_err = 0;

    // first frame latency and slot format
    rst = 1; step(); rst = 0;
    a_wr = 1; a_addr = 9'd0; a_data = 8'hA5;
    step();
    en = 1; n = 0;
    while (!tx_send && n < 300) begin step(); n++; end
    chk("send_lat", 32'(n), 32'd102);
    chk("slot0_fmt", 32'(tx_data[10:0]), 32'h600);
    chk("slot1_fmt", 32'(tx_data[21:11]), 32'(11'b11_10100101_0));

    // three completed frames
    tx_delay = 60; n = 0;
    while (frame_cnt != 16'd3 && n < 1000) begin step(); n++; end
    chk("frames3", 32'(frame_cnt), 32'd3);
    chk("no_ovr", 32'(overrun), 32'd0);

    // timeout: transmitter never answers
    tx_delay = -1;
    wait_send("tmo_send", 300);
    fc = m_fcnt; n = 0;
    while (!timeout_err && n < 400) begin step(); n++; end
    chk("tmo_lat", 32'(n), 32'd201);
    chk("tmo_fcnt", 32'(frame_cnt), 32'(fc));
    tx_delay = 40;
    step();
    wait_send("tmo_reload", 300);

    // slow transmitter overlaps two ticks; then reset during WAIT
    rst = 1; step(); rst = 0;
    tx_delay = 199;
    wait_send("ovr_send", 300);
    n = 0;
    while (!overrun && n < 300) begin step(); n++; end
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    n = 0;
    while (frame_cnt != 16'd1 && n < 300) begin step(); n++; end
    chk("ovr_frame1", 32'(frame_cnt), 32'd1);
    wait_send("ovr_extra", 50);
    repeat (10) step();
    rst = 1; step(); rst = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);

    // random traffic
    rand_delay = 1;
    for (int c = 0; c < 12000; c++) begin
      if (!a_wr && $urandom_range(0, 3) == 0) begin
        a_wr = 1; a_addr = 9'($urandom_range(0, 511)); a_data = 8'($urandom);
      end
      if (!b_wr && $urandom_range(0, 3) == 0) begin
        b_wr = 1; b_addr = 9'($urandom_range(0, 511)); b_data = 8'($urandom);
      end
      if ($urandom_range(0, 499) == 0) en = !en;
      clr_err = ($urandom_range(0, 149) == 0);
      rst     = ($urandom_range(0, 2999) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
